// File: rtl/conv_sched_ctrl_pkg.sv
// Shared definitions for the convolution scheduler: state encodings,
// default frame geometry and the derived output-map size.
package conv_sched_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } conv_state_e;

    localparam int IFM_W = 14;
    localparam int IFM_H = 14;
    localparam int K     = 3;
    localparam int OUT_W = IFM_W - K + 1;
    localparam int OUT_H = IFM_H - K + 1;

    // Cycles between the last accepted pixel and the DONE state; matches
    // the two register stages (window sum, conv result) of the datapath.
    localparam int DRAIN_CYCLES = 2;

endpackage

// File: rtl/conv_pix_counter.sv
// Raster position of the next IFM pixel to be accepted.
// Column wraps at the row end; the whole position wraps after the last pixel.
module conv_pix_counter #(
    parameter int IFM_W = 14,
    parameter int IFM_H = 14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       adv,
    output logic [3:0] row,
    output logic [3:0] col,
    output logic       last
);

    logic [3:0] row_reg;
    logic [3:0] col_reg;

    // Advance one pixel per accepted beat; clear returns to the frame origin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_reg <= 4'd0;
            col_reg <= 4'd0;
        end else if (clr) begin
            row_reg <= 4'd0;
            col_reg <= 4'd0;
        end else if (adv) begin
            if (col_reg == 4'(IFM_W - 1)) begin
                col_reg <= 4'd0;
                row_reg <= (row_reg == 4'(IFM_H - 1)) ? 4'd0 : row_reg + 4'd1;
            end else begin
                col_reg <= col_reg + 4'd1;
            end
        end
    end

    assign row  = row_reg;
    assign col  = col_reg;
    assign last = (row_reg == 4'(IFM_H - 1)) && (col_reg == 4'(IFM_W - 1));

endmodule

// File: rtl/conv_sched_ctrl.sv
// Sequencer for the 3x3 convolution datapath: accepts a frame of IFM
// pixels, loads the weight buffer from the first K*K beats, flags complete
// windows and tracks the output-map coordinate through the MAC pipeline.
module conv_sched_ctrl #(
    parameter int IFM_W = conv_sched_ctrl_pkg::IFM_W,
    parameter int IFM_H = conv_sched_ctrl_pkg::IFM_H,
    parameter int K     = conv_sched_ctrl_pkg::K
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       wgt_we,
    output logic [3:0] wgt_addr,
    output logic       ifm_shift,
    output logic       win_valid,
    output logic       out_valid,
    output logic [3:0] out_row,
    output logic [3:0] out_col,
    output logic       busy,
    output logic       done,
    output logic       ovf_err
);

    import conv_sched_ctrl_pkg::*;

    localparam int WGT_N = K * K;

    conv_state_e state_reg;
    logic        drain_cnt_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        ovf_reg;
    logic [3:0]  beat_reg;

    logic        win_valid_reg;
    logic [3:0]  win_row_reg;
    logic [3:0]  win_col_reg;
    logic        out_valid_reg;
    logic [3:0]  out_row_reg;
    logic [3:0]  out_col_reg;

    logic        acc;
    logic        cnt_clr;
    logic        win_hit;
    logic [3:0]  pix_row;
    logic [3:0]  pix_col;
    logic        pix_last;

    assign acc      = in_valid && ((state_reg == ST_IDLE) || (state_reg == ST_STREAM));
    assign cnt_clr  = (state_reg == ST_DONE);
    assign win_hit  = acc && (pix_row >= 4'(K - 1)) && (pix_col >= 4'(K - 1));

    assign ifm_shift = acc;
    assign wgt_we    = acc && (beat_reg < 4'(WGT_N));
    assign wgt_addr  = (beat_reg < 4'(WGT_N)) ? beat_reg : 4'd0;

    conv_pix_counter #(
        .IFM_W (IFM_W),
        .IFM_H (IFM_H)
    ) u_pix_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .adv  (acc),
        .row  (pix_row),
        .col  (pix_col),
        .last (pix_last)
    );

    // Frame sequencing: stream pixels, drain the datapath, pulse done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            drain_cnt_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (acc) begin
                        state_reg <= ST_STREAM;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (acc && pix_last) begin
                        state_reg     <= ST_DRAIN;
                        drain_cnt_reg <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_reg == 1'(DRAIN_CYCLES - 1)) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Weight beat index saturates once the buffer is full; restarts per frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_reg <= 4'd0;
        end else if (cnt_clr) begin
            beat_reg <= 4'd0;
        end else if (acc && (beat_reg < 4'(WGT_N))) begin
            beat_reg <= beat_reg + 4'd1;
        end
    end

    // Sticky overflow: a beat offered while the block cannot take it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (in_valid && ((state_reg == ST_DRAIN) || (state_reg == ST_DONE))) begin
            ovf_reg <= 1'b1;
        end
    end

    // Coordinate pipeline tracking the window-sum and conv-result stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid_reg <= 1'b0;
            win_row_reg   <= 4'd0;
            win_col_reg   <= 4'd0;
            out_valid_reg <= 1'b0;
            out_row_reg   <= 4'd0;
            out_col_reg   <= 4'd0;
        end else begin
            win_valid_reg <= win_hit;
            if (win_hit) begin
                win_row_reg <= pix_row - 4'(K - 1);
                win_col_reg <= pix_col - 4'(K - 1);
            end
            out_valid_reg <= win_valid_reg;
            if (win_valid_reg) begin
                out_row_reg <= win_row_reg;
                out_col_reg <= win_col_reg;
            end
        end
    end

    assign win_valid = win_valid_reg;
    assign out_valid = out_valid_reg;
    assign out_row   = out_row_reg;
    assign out_col   = out_col_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign ovf_err   = ovf_reg;

endmodule

// File: tb/tb_conv_sched_ctrl.sv
// Bench for conv_sched_ctrl: frames of pixels with various gap patterns,
// checked cycle by cycle against a frame-level model (pixel index, blackout
// countdown after the last pixel, raster index of the next expected output).
module tb_conv_sched_ctrl;

    localparam int W    = 14;
    localparam int H    = 14;
    localparam int KK   = 3;
    localparam int OW   = W - KK + 1;
    localparam int OH   = H - KK + 1;
    localparam int NOUT = OW * OH;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       wgt_we;
    logic [3:0] wgt_addr;
    logic       ifm_shift;
    logic       win_valid;
    logic       out_valid;
    logic [3:0] out_row;
    logic [3:0] out_col;
    logic       busy;
    logic       done;
    logic       ovf_err;

    conv_sched_ctrl #(
        .IFM_W (W),
        .IFM_H (H),
        .K     (KK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .wgt_we    (wgt_we),
        .wgt_addr  (wgt_addr),
        .ifm_shift (ifm_shift),
        .win_valid (win_valid),
        .out_valid (out_valid),
        .out_row   (out_row),
        .out_col   (out_col),
        .busy      (busy),
        .done      (done),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_p;     // pixels accepted so far in the current frame
    int m_bo;    // cycles left in which beats are refused (drain + done)
    int m_k;     // raster index of the next expected output
    bit m_win;   // a window completed by the previous accepted pixel
    bit m_out;   // a conv result is expected this cycle
    bit m_ovf;
    int pulses = 0;
    int dones  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_p = 0; m_bo = 0; m_k = 0; m_win = 0; m_out = 0; m_ovf = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " win_valid"}, win_valid, 0);
        check_eq({tag, " out_valid"}, out_valid, 0);
        check_eq({tag, " out_row"}, out_row, 0);
        check_eq({tag, " out_col"}, out_col, 0);
        check_eq({tag, " busy"}, busy, 0);
        check_eq({tag, " done"}, done, 0);
        check_eq({tag, " ovf_err"}, ovf_err, 0);
        check_eq({tag, " wgt_addr"}, wgt_addr, 0);
    endtask

    task automatic check_regs();
        check_eq("win_valid", win_valid, m_win);
        check_eq("out_valid", out_valid, m_out);
        check_eq("busy", busy, (m_p > 0) || (m_bo > 0));
        check_eq("done", done, m_bo == 1);
        check_eq("ovf_err", ovf_err, m_ovf);
        if (m_out) begin
            check_eq("out_row", out_row, m_k / OW);
            check_eq("out_col", out_col, m_k % OW);
            m_k = (m_k + 1) % NOUT;
        end
        if (out_valid === 1'b1) pulses++;
        if (done === 1'b1) dones++;
    endtask

    // One clock cycle: called just after a falling edge.
    task automatic step(input logic v);
        bit acc;
        int r, c;
        check_regs();
        in_valid = v;
        #1;
        acc = v && (m_bo == 0);
        check_eq("ifm_shift", ifm_shift, acc);
        check_eq("wgt_we", wgt_we, acc && (m_p < KK * KK));
        check_eq("wgt_addr", wgt_addr, (m_p < KK * KK) ? m_p : 0);
        @(posedge clk);
        if (m_bo > 0) begin
            if (v) m_ovf = 1;
            m_bo--;
        end
        r = m_p / W;
        c = m_p % W;
        m_out = m_win;
        m_win = acc && (r >= KK - 1) && (c >= KK - 1);
        if (acc) begin
            m_p++;
            if (m_p == NPIX) begin
                m_p  = 0;
                m_bo = 3;
            end
        end
        @(negedge clk);
    endtask

    // mode 0: continuous, 1: gap after every 5th beat, 2: random gaps
    task automatic run_frame(input string name, input int beats, input int mode);
        int p0;
        int d0;
        int guard;
        p0 = pulses;
        d0 = dones;
        guard = 0;
        for (int s = 0; s < beats; s++) begin
            step(1'b1);
            if (mode == 1 && ((s + 1) % 5 == 0)) step(1'b0);
            if (mode == 2 && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) step(1'b0);
            end
        end
        while (m_bo > 0 && guard < 16) begin
            step(1'b0);
            guard++;
        end
        check_eq({name, " outputs"}, pulses - p0, NOUT);
        check_eq({name, " done pulses"}, dones - d0, 1);
        $display("frame %s: beats=%0d outputs=%0d done=%0d ovf=%0d", name, beats,
                 pulses - p0, dones - d0, ovf_err);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_model();
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        run_frame("s1_continuous", NPIX, 0);
        run_frame("s2_gap5", NPIX, 1);
        run_frame("s3_overrun", NPIX + 3, 0);
        check_eq("s3 ovf sticky", ovf_err, 1);

        // Abort mid-frame after beat 100 with an asynchronous reset
        for (int s = 0; s <= 100; s++) step(1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("s4_abort");
        begin
            int d0;
            d0 = dones;
            @(negedge clk);
            check_reset_outputs("s4_hold");
            reset_model();
            rst = 1'b0;
            for (int i = 0; i < 4; i++) step(1'b0);
            check_eq("s4 no done after abort", dones - d0, 0);
        end
        run_frame("s4_fresh", NPIX, 0);

        // Back-to-back frames: each starts the cycle after done
        run_frame("s5_first", NPIX, 0);
        run_frame("s5_second", NPIX, 0);

        run_frame("rand_a", NPIX, 2);
        run_frame("rand_b", NPIX, 2);
        run_frame("gap5_b2b", NPIX, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
